// File: rtl/tinker_data_mem_if.sv
// Request/response bus between the tinker core load/store path and tinker_data_mem.
// The master drives requests and the slave (memory) drives ready, response and busy.
interface tinker_data_mem_if #(
    parameter int ADDR_W = 64
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              rsp_valid;
    logic [63:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/tinker_data_mem.sv
// Byte-addressed little-endian data memory with a single outstanding request,
// fixed access latency and 1/2/4/8-byte accesses; bad accesses return an error.
module tinker_data_mem #(
    parameter int unsigned MEM_BYTES   = 524288,
    parameter int          ADDR_W      = 64,
    parameter int unsigned LATENCY     = 2,
    parameter bit          RESET_CLEAR = 1'b1
) (
    input logic               clk,
    input logic               reset,
    tinker_data_mem_if.slave  bus
);
    localparam int unsigned IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [7:0]        mem_q [MEM_BYTES];

    // With LATENCY==1 the response is produced on the accepting edge, so the
    // access is evaluated on the live bus request instead of the latched copy.
    logic              cur_write;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [63:0]       cur_wdata;
    logic              cur_err;
    logic [ADDR_W:0]   end_addr;
    logic              misalign;
    int unsigned       nbytes;
    logic [IDX_W-1:0]  idx [8];
    logic [63:0]       load_data;
    logic              do_resp;

    always_comb begin
        cur_write = write_q;
        cur_size  = size_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == IDLE) begin
            cur_write = bus.req_write;
            cur_size  = bus.req_size;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end
        nbytes = 32'd1 << cur_size;
        unique case (cur_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = cur_addr[0];
            2'd2:    misalign = |cur_addr[1:0];
            default: misalign = |cur_addr[2:0];
        endcase
        end_addr = {1'b0, cur_addr} + (ADDR_W+1)'(nbytes);
        cur_err  = misalign | (end_addr > (ADDR_W+1)'(MEM_BYTES));
        load_data = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx[i] = cur_addr[IDX_W-1:0] + IDX_W'(i);
            if (i < nbytes) load_data[8*i +: 8] = mem_q[idx[i]];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        do_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (LATENCY <= 1) begin
                        state_d = RESP;
                        do_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    do_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (do_resp) begin
            err_d   = cur_err;
            rdata_d = (!cur_write && !cur_err) ? load_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (RESET_CLEAR) begin
                for (int unsigned i = 0; i < MEM_BYTES; i++) mem_q[i] <= '0;
            end
        end else if (do_resp && cur_write && !cur_err) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (i < nbytes) mem_q[idx[i]] <= cur_wdata[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.busy      = (state_q != IDLE) && !reset;
    assign bus.rsp_valid = (state_q == RESP) && !reset;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
